// File: rtl/divf_iter.sv
// divf_iter: elastic IEEE-754 binary32 divider, lhs / rhs, iterative radix-2 restoring.
// Both operand channels are joined and one division is in flight at a time.
// The result is held on a registered valid/ready channel.
// Optional macro DIVF_EARLY_EXIT_EN: special operands skip DIVIDE/ROUND and reach DONE right after UNPACK.
`timescale 1ns/1ps
module divf_iter #(
   parameter int unsigned DATA_TYPE = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_TYPE-1:0] lhs,
   input  logic                 lhs_valid,
   input  logic [DATA_TYPE-1:0] rhs,
   input  logic                 rhs_valid,
   input  logic                 result_ready,
   output logic [DATA_TYPE-1:0] result,
   output logic                 result_valid,
   output logic                 lhs_ready,
   output logic                 rhs_ready
);

   localparam int unsigned EXP_W  = 8;
   localparam int unsigned FRAC_W = 23;
   localparam int unsigned MANT_W = 24;
   localparam int unsigned Q_W    = 26;
   localparam int unsigned REM_W  = 25;
   localparam int unsigned E_W    = 10;
   localparam int unsigned CNT_W  = 5;
   localparam int unsigned ITER   = 26;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);
   localparam logic [DATA_TYPE-1:0] QNAN  = DATA_TYPE'(32'h7FC0_0000);

   typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_DIVIDE, S_ROUND, S_DONE} state_t;

   state_t                 state_q, state_d;
   logic [DATA_TYPE-1:0]   a_q, a_d, b_q, b_d;
   logic                   sign_q, sign_d;
   logic signed [E_W-1:0]  exp_q, exp_d;
   logic [MANT_W-1:0]      mb_q, mb_d;
   logic [REM_W-1:0]       rem_q, rem_d;
   logic [Q_W-1:0]         q_q, q_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   spec_q, spec_d;
   logic [DATA_TYPE-1:0]   spec_res_q, spec_res_d;
   logic [DATA_TYPE-1:0]   result_q, result_d;
   logic                   result_valid_q, result_valid_d;

   logic                   accept_c;
   logic [EXP_W-1:0]       ea, eb;
   logic [FRAC_W-1:0]      fa, fb;
   logic                   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sgn;
   logic [MANT_W-1:0]      ma_c, mb_c;
   logic signed [E_W-1:0]  e_c;
   logic                   spec_c;
   logic [DATA_TYPE-1:0]   spec_res_c;
   logic [REM_W:0]         trial;
   logic                   q_bit;
   logic [REM_W-1:0]       rem_keep;
   logic                   sticky, round_up;
   logic [MANT_W:0]        mant_rnd;
   logic signed [E_W-1:0]  exp_rnd;
   logic [FRAC_W-1:0]      frac_rnd;
   logic [DATA_TYPE-1:0]   round_c;

   // Join: both operands are taken together, only while idle and out of reset.
   assign accept_c     = (state_q == S_IDLE) & lhs_valid & rhs_valid & ~rst;
   assign lhs_ready    = accept_c;
   assign rhs_ready    = accept_c;
   assign result       = result_q;
   assign result_valid = result_valid_q;

   // Operand decode: denormals flush to zero, special-case classification and result.
   always_comb begin
      ea     = a_q[30:23];
      eb     = b_q[30:23];
      fa     = a_q[22:0];
      fb     = b_q[22:0];
      sgn    = a_q[31] ^ b_q[31];
      a_zero = (ea == '0);
      b_zero = (eb == '0);
      a_inf  = (ea == '1) && (fa == '0);
      b_inf  = (eb == '1) && (fb == '0);
      a_nan  = (ea == '1) && (fa != '0);
      b_nan  = (eb == '1) && (fb != '0);
      ma_c   = a_zero ? '0 : {1'b1, fa};
      mb_c   = b_zero ? '0 : {1'b1, fb};
      e_c    = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
      spec_c     = 1'b1;
      spec_res_c = '0;
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
         spec_res_c = QNAN;
      end else if (b_zero || a_inf) begin
         spec_res_c = {sgn, 8'hFF, 23'd0};
      end else if (b_inf || a_zero) begin
         spec_res_c = {sgn, 31'd0};
      end else begin
         spec_c = 1'b0;
      end
   end

   // One restoring step: subtract divisor when the trial remainder stays non-negative.
   always_comb begin
      trial    = {1'b0, rem_q} - {2'b00, mb_q};
      q_bit    = ~trial[REM_W];
      rem_keep = q_bit ? trial[REM_W-1:0] : rem_q;
   end

   // Round-to-nearest-even of q with guard/round/sticky; overflow to inf, underflow to zero.
   always_comb begin
      sticky   = |rem_q;
      round_up = q_q[1] & (q_q[0] | sticky | q_q[2]);
      mant_rnd = {1'b0, q_q[Q_W-1:2]} + (MANT_W+1)'(round_up);
      exp_rnd  = exp_q + $signed({9'd0, mant_rnd[MANT_W]});
      frac_rnd = mant_rnd[MANT_W] ? mant_rnd[MANT_W-1:1] : mant_rnd[FRAC_W-1:0];
      if (spec_q) begin
         round_c = spec_res_q;
      end else if (exp_rnd >= 10'sd255) begin
         round_c = {sign_q, 8'hFF, 23'd0};
      end else if (exp_rnd <= 10'sd0) begin
         round_c = {sign_q, 31'd0};
      end else begin
         round_c = {sign_q, exp_rnd[7:0], frac_rnd};
      end
   end

   // Next-state and datapath updates for the divider FSM.
   always_comb begin
      state_d        = state_q;
      a_d            = a_q;
      b_d            = b_q;
      sign_d         = sign_q;
      exp_d          = exp_q;
      mb_d           = mb_q;
      rem_d          = rem_q;
      q_d            = q_q;
      cnt_d          = cnt_q;
      spec_d         = spec_q;
      spec_res_d     = spec_res_q;
      result_d       = result_q;
      result_valid_d = result_valid_q;
      case (state_q)
         S_IDLE: begin
            if (accept_c) begin
               a_d     = lhs;
               b_d     = rhs;
               state_d = S_UNPACK;
            end
         end
         S_UNPACK: begin
            sign_d     = sgn;
            spec_d     = spec_c;
            spec_res_d = spec_res_c;
            mb_d       = mb_c;
            q_d        = '0;
            cnt_d      = '0;
            if (ma_c < mb_c) begin
               rem_d = REM_W'({ma_c, 1'b0});
               exp_d = e_c - 10'sd1;
            end else begin
               rem_d = REM_W'(ma_c);
               exp_d = e_c;
            end
            state_d = S_DIVIDE;
`ifdef DIVF_EARLY_EXIT_EN
            if (spec_c) begin
               result_d       = spec_res_c;
               result_valid_d = 1'b1;
               state_d        = S_DONE;
            end
`endif
         end
         S_DIVIDE: begin
            rem_d = REM_W'({rem_keep, 1'b0});
            q_d   = {q_q[Q_W-2:0], q_bit};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_ITER) state_d = S_ROUND;
         end
         S_ROUND: begin
            result_d       = round_c;
            result_valid_d = 1'b1;
            state_d        = S_DONE;
         end
         S_DONE: begin
            if (result_ready) begin
               result_valid_d = 1'b0;
               state_d        = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset discards any in-flight division.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         a_q            <= '0;
         b_q            <= '0;
         sign_q         <= 1'b0;
         exp_q          <= '0;
         mb_q           <= '0;
         rem_q          <= '0;
         q_q            <= '0;
         cnt_q          <= '0;
         spec_q         <= 1'b0;
         spec_res_q     <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         a_q            <= a_d;
         b_q            <= b_d;
         sign_q         <= sign_d;
         exp_q          <= exp_d;
         mb_q           <= mb_d;
         rem_q          <= rem_d;
         q_q            <= q_d;
         cnt_q          <= cnt_d;
         spec_q         <= spec_d;
         spec_res_q     <= spec_res_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
      end
   end

endmodule

// File: tb/tb_divf_iter.sv
// tb_divf_iter: directed table, handshake corner sequences and random ops for divf_iter.
`timescale 1ns/1ps
module tb_divf_iter;

   logic        clk, rst;
   logic [31:0] lhs, rhs, result;
   logic        lhs_valid, rhs_valid, result_ready;
   logic        result_valid, lhs_ready, rhs_ready;

`ifdef DIVF_EARLY_EXIT_EN
   localparam int LAT_SP = 2;
`else
   localparam int LAT_SP = 29;
`endif
   localparam int LAT_N  = 29;
   localparam int BUDGET = 60;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      int          lat;
   } vec_t;

   int n_cmp  = 0;
   int n_fail = 0;

   divf_iter #(.DATA_TYPE(32)) dut (
      .clk(clk), .rst(rst),
      .lhs(lhs), .lhs_valid(lhs_valid),
      .rhs(rhs), .rhs_valid(rhs_valid),
      .result_ready(result_ready),
      .result(result), .result_valid(result_valid),
      .lhs_ready(lhs_ready), .rhs_ready(rhs_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_hex(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", nm, act, exp_v);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp_v);
      n_cmp++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
      end
   endtask

   // Reference: special rules first, otherwise divide in double and round to binary32 (RNE).
   function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                           output bit sp);
      logic        s, az, bz, ai, bi, an, bn, g, st, up;
      logic [7:0]  ea, eb;
      logic [22:0] fa, fb, fr;
      logic [63:0] d;
      logic [24:0] m;
      real         va, vb, vq;
      int          be;
      s  = a[31] ^ b[31];
      ea = a[30:23];  eb = b[30:23];
      fa = a[22:0];   fb = b[22:0];
      az = (ea == 8'd0);  bz = (eb == 8'd0);
      ai = (ea == 8'hFF) && (fa == 23'd0);
      bi = (eb == 8'hFF) && (fb == 23'd0);
      an = (ea == 8'hFF) && (fa != 23'd0);
      bn = (eb == 8'hFF) && (fb != 23'd0);
      sp = 1'b1;
      if (an || bn || (az && bz) || (ai && bi)) return 32'h7FC00000;
      if (bz || ai) return {s, 8'hFF, 23'd0};
      if (bi || az) return {s, 31'd0};
      sp = 1'b0;
      va = $bitstoreal({1'b0, 11'(int'(ea) + 896), fa, 29'd0});
      vb = $bitstoreal({1'b0, 11'(int'(eb) + 896), fb, 29'd0});
      vq = va / vb;
      d  = $realtobits(vq);
      be = int'(d[62:52]) - 896;
      m  = {2'b01, d[51:29]};
      g  = d[28];
      st = |d[27:0];
      up = g && (st || m[0]);
      m  = m + 25'(up);
      if (m[24]) be++;
      fr = m[24] ? 23'd0 : m[22:0];
      if (be >= 255) return {s, 8'hFF, 23'd0};
      if (be <= 0) return {s, 31'd0};
      return {s, 8'(be), fr};
   endfunction

   function automatic logic [31:0] rand_f();
      int          r;
      logic [7:0]  e;
      logic [22:0] f;
      r = int'($urandom_range(0, 19));
      f = 23'($urandom);
      if (r == 0) e = 8'd0;
      else if (r == 1) e = 8'hFF;
      else if (r < 12) e = 8'($urandom_range(100, 154));
      else e = 8'($urandom_range(1, 254));
      if (r <= 1 && $urandom_range(0, 1) == 1) f = 23'd0;
      return {1'($urandom), e, f};
   endfunction

   // Called just after the accepting edge; checks latency, value, busy readys and one-cycle valid.
   task automatic wait_result(input string nm, input logic [31:0] exq, input int lat);
      int k    = 0;
      int busy = 0;
      bit seen = 1'b0;
      while (!seen && k < BUDGET) begin
         @(negedge clk);
         k++;
         if (lhs_ready || rhs_ready) busy++;
         seen = result_valid;
      end
      chk_int({nm, "_lat"}, seen ? k : -1, lat);
      chk_hex({nm, "_res"}, result, exq);
      chk_int({nm, "_busy"}, busy, 0);
      lhs_valid = 1'b0;
      rhs_valid = 1'b0;
      @(negedge clk);
      chk_int({nm, "_drop"}, int'(result_valid), 0);
   endtask

   task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exq, input int lat);
      @(negedge clk);
      lhs = a;  rhs = b;
      lhs_valid = 1'b1;  rhs_valid = 1'b1;  result_ready = 1'b1;
      #1;
      chk_int({nm, "_acc"}, int'({lhs_ready, rhs_ready}), 3);
      @(posedge clk);
      #1;
      lhs = ~a;  rhs = ~b;
      wait_result(nm, exq, lat);
   endtask

   initial begin
      vec_t        tbl [0:13];
      logic [31:0] a, b, exq;
      bit          sp, seen;
      int          bad_rdy, bad_stab, k;

      tbl[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, LAT_N};
      tbl[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, LAT_N};
      tbl[2]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, LAT_N};
      tbl[3]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, LAT_SP};
      tbl[4]  = '{32'h80000000, 32'h00000000, 32'h7FC00000, LAT_SP};
      tbl[5]  = '{32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, LAT_N};
      tbl[6]  = '{32'h00400000, 32'h3F800000, 32'h00000000, LAT_SP};
      tbl[7]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, LAT_SP};
      tbl[8]  = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, LAT_SP};
      tbl[9]  = '{32'h7F800000, 32'hC0000000, 32'hFF800000, LAT_SP};
      tbl[10] = '{32'h40000000, 32'hFF800000, 32'h80000000, LAT_SP};
      tbl[11] = '{32'h00800000, 32'h4B000000, 32'h00000000, LAT_N};
      tbl[12] = '{32'hC0A00000, 32'h40000000, 32'hC0200000, LAT_N};
      tbl[13] = '{32'h3F800000, 32'h00000001, 32'h7F800000, LAT_SP};

      // Reset state, with operands offered during reset.
      rst = 1'b1;
      lhs = 32'h40C00000;  rhs = 32'h40000000;
      lhs_valid = 1'b1;  rhs_valid = 1'b1;  result_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_int("rst_ready", int'({lhs_ready, rhs_ready}), 0);
      chk_int("rst_valid", int'(result_valid), 0);
      chk_hex("rst_result", result, 32'h0);
      rst = 1'b0;  lhs_valid = 1'b0;  rhs_valid = 1'b0;

      for (int i = 0; i < 14; i++)
         run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].lat);

      // Join: lhs alone is never taken; both readys rise with rhs_valid.
      @(negedge clk);
      lhs = 32'hC0A00000;  rhs = 32'h40000000;
      lhs_valid = 1'b1;  rhs_valid = 1'b0;  result_ready = 1'b1;
      bad_rdy = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (lhs_ready || rhs_ready) bad_rdy++;
         @(negedge clk);
      end
      chk_int("join_alone", bad_rdy, 0);
      rhs_valid = 1'b1;
      #1;
      chk_int("join_both", int'({lhs_ready, rhs_ready}), 3);
      @(posedge clk);
      #1;
      lhs = 32'h12345678;
      wait_result("join", 32'hC0200000, LAT_N);

      // Backpressure: hold result through cycle 40, new operands waiting, accept at 42.
      @(negedge clk);
      lhs = 32'h40C00000;  rhs = 32'h40000000;
      lhs_valid = 1'b1;  rhs_valid = 1'b1;  result_ready = 1'b0;
      #1;
      chk_int("bp_acc", int'({lhs_ready, rhs_ready}), 3);
      @(posedge clk);
      #1;
      lhs = 32'h3F800000;  rhs = 32'h40400000;
      bad_rdy = 0;  bad_stab = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (lhs_ready || rhs_ready) bad_rdy++;
         if (c >= 29 && (!result_valid || result !== 32'h40400000)) bad_stab++;
         if (c < 29 && result_valid) bad_stab++;
      end
      chk_int("bp_ready", bad_rdy, 0);
      chk_int("bp_stable", bad_stab, 0);
      @(negedge clk);
      result_ready = 1'b1;
      #1;
      chk_int("bp_valid41", int'(result_valid), 1);
      chk_hex("bp_res41", result, 32'h40400000);
      @(negedge clk);
      #1;
      chk_int("bp_valid42", int'(result_valid), 0);
      chk_int("bp_acc42", int'({lhs_ready, rhs_ready}), 3);
      @(posedge clk);
      #1;
      lhs = 32'h0;
      wait_result("bp_next", 32'h3EAAAAAB, LAT_N);

      // Reset at cycle 10 of a division; new operands taken right after release.
      @(negedge clk);
      lhs = 32'h40C00000;  rhs = 32'h40000000;
      lhs_valid = 1'b1;  rhs_valid = 1'b1;  result_ready = 1'b1;
      @(posedge clk);
      #1;
      lhs_valid = 1'b0;  rhs_valid = 1'b0;
      repeat (10) @(negedge clk);
      #2;
      rst = 1'b1;
      lhs = 32'h3F800000;  rhs = 32'h40400000;
      lhs_valid = 1'b1;  rhs_valid = 1'b1;
      #1;
      chk_int("rstmid_valid", int'(result_valid), 0);
      chk_int("rstmid_ready", int'({lhs_ready, rhs_ready}), 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_int("rstmid_acc", int'({lhs_ready, rhs_ready}), 3);
      @(posedge clk);
      #1;
      lhs = 32'h0;
      wait_result("rstmid_next", 32'h3EAAAAAB, LAT_N);

      // Reset while a result is held under backpressure.
      @(negedge clk);
      lhs = 32'h3F800000;  rhs = 32'h3F800000;
      lhs_valid = 1'b1;  rhs_valid = 1'b1;  result_ready = 1'b0;
      @(posedge clk);
      #1;
      lhs_valid = 1'b0;  rhs_valid = 1'b0;
      k = 0;  seen = 1'b0;
      while (!seen && k < BUDGET) begin
         @(negedge clk);
         k++;
         seen = result_valid;
      end
      chk_int("rstdone_seen", int'(seen), 1);
      chk_hex("rstdone_res", result, 32'h3F800000);
      #2;
      rst = 1'b1;
      #1;
      chk_int("rstdone_valid", int'(result_valid), 0);
      chk_hex("rstdone_result", result, 32'h0);
      @(negedge clk);
      rst = 1'b0;  result_ready = 1'b1;

      // Random operands against the reference model.
      for (int i = 0; i < 150; i++) begin
         a   = rand_f();
         b   = rand_f();
         exq = ref_div(a, b, sp);
         run_op($sformatf("rnd%0d", i), a, b, exq, sp ? LAT_SP : LAT_N);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
